// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage consumer of the EXE/MEM pipeline register. Turns load/store
//   control into a req/ack transaction on the data-memory port. It holds the
//   pipeline frozen while an access is outstanding and registers the results
//   into the MEM/WB boundary.
//
//   State | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no access outstanding; a new op issues mem_req this cycle
//   ACCESS| request outstanding, waiting for mem_ack or the timeout
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   wb_en_in .. dest_in       EXE/MEM register outputs
//   mem_req/we/addr/wdata     data-memory request side (combinational)
//   mem_ack, mem_rdata        data-memory completion side
//   freeze                    stall for upstream stages (combinational)
//   *_out                     registered MEM/WB boundary
//   mem_err                   sticky: timeout or simultaneous read/write seen
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int          AW        = 6,
  parameter int          TIMEOUT   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_en_in,
  input  logic          mem_r_en_in,
  input  logic          mem_w_en_in,
  input  logic [31:0]   alu_res_in,
  input  logic [31:0]   val_rm_in,
  input  logic [3:0]    dest_in,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic          freeze,
  output logic          wb_en_out,
  output logic          mem_r_en_out,
  output logic [31:0]   alu_res_out,
  output logic [31:0]   mem_rdata_out,
  output logic [3:0]    dest_out,
  output logic          mem_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   offset;
  logic          mem_op;
  logic          is_load;
  logic          rw_conflict;
  logic          timeout;
  logic          acked;
  logic          complete;

  assign mem_op      = mem_r_en_in | mem_w_en_in;
  // A simultaneous read and write is executed as a write.
  assign is_load     = mem_r_en_in & ~mem_w_en_in;
  assign rw_conflict = mem_r_en_in & mem_w_en_in;

  // The IDLE cycle that issues the request counts as the first waiting
  // cycle, so the count (cleared on entering ACCESS) lags by one and the
  // request is abandoned after TIMEOUT cycles of mem_req.
  assign timeout  = (state == ACCESS) && (cnt == CNT_LAST);

  // Gating with rst drops the request immediately on an async reset.
  assign mem_req  = rst & mem_op & ~timeout;
  assign acked    = mem_req & mem_ack;
  assign freeze   = mem_req & ~mem_ack;
  assign complete = ~mem_op | acked | timeout;

  assign offset    = alu_res_in - BASE_ADDR;
  assign mem_addr  = offset[AW+1:2];
  assign mem_we    = mem_w_en_in;
  assign mem_wdata = (mem_req && mem_w_en_in) ? val_rm_in : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      wb_en_out     <= 1'b0;
      mem_r_en_out  <= 1'b0;
      alu_res_out   <= 32'd0;
      mem_rdata_out <= 32'd0;
      dest_out      <= 4'd0;
      mem_err       <= 1'b0;
    end else begin
      if (timeout || (mem_req && rw_conflict))
        mem_err <= 1'b1;

      case (state)
        IDLE: begin
          if (mem_op && !mem_ack) begin
            state <= ACCESS;
            cnt   <= '0;
          end
        end
        ACCESS: begin
          if (complete)
            state <= IDLE;
          else if (cnt != CNT_LAST)
            cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (complete) begin
        wb_en_out     <= wb_en_in;
        mem_r_en_out  <= is_load;
        alu_res_out   <= alu_res_in;
        dest_out      <= dest_in;
        mem_rdata_out <= (is_load && acked) ? mem_rdata : 32'd0;
      end else begin
        // Bubble into write-back while stalled; data fields hold.
        wb_en_out    <= 1'b0;
        mem_r_en_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Expected MEM/WB results are queued
// when an op is driven and compared when the unit completes the op.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        mem_req, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        freeze;
  logic        wb_en_out, mem_r_en_out;
  logic [31:0] alu_res_out, mem_rdata_out;
  logic [3:0]  dest_out;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wb;
    logic        r_en;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [3:0]  dest;
  } exp_t;

  exp_t sb[$];

  mem_access_unit #(.BASE_ADDR(32'd1024), .AW(6), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .freeze(freeze),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out),
    .mem_rdata_out(mem_rdata_out), .dest_out(dest_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    alu_res_in = 0; val_rm_in = 0; dest_in = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  // Called just after a rising edge. ack_at: cycle index (0 = issue cycle)
  // at which mem_ack is pulsed; negative means never acknowledge.
  task automatic do_op(input string tag, input logic wb, input logic r, input logic w,
                       input logic [31:0] alu, input logic [31:0] val,
                       input logic [3:0] dst, input int ack_at, input logic [31:0] rdata);
    exp_t        e;
    exp_t        got;
    int          frz = 0;
    int          exp_frz;
    bit          done = 0;
    bit          is_mem = r | w;
    bit          is_ld = r & ~w;
    bit          to = is_mem && (ack_at < 0);
    logic [31:0] d;
    d = alu - 32'd1024;
    wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    alu_res_in = alu; val_rm_in = val; dest_in = dst;
    e.wb = wb; e.r_en = is_ld; e.alu = alu; e.dest = dst;
    e.rdata = (is_ld && !to) ? rdata : 32'd0;
    sb.push_back(e);
    exp_frz = !is_mem ? 0 : (to ? 16 : ack_at);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (is_mem && c == ack_at) begin mem_ack = 1; mem_rdata = rdata; end
      #1;
      if (c == 0 && is_mem) begin
        check({tag, ".mem_req"}, {31'd0, mem_req}, 32'd1);
        check({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, w});
        check({tag, ".mem_addr"}, {26'd0, mem_addr}, {26'd0, d[7:2]});
        if (w) check({tag, ".mem_wdata"}, mem_wdata, val);
      end
      if (freeze) frz++; else done = 1;
      @(posedge clk); #1;
      mem_ack = 0;
      if (!done) begin
        check({tag, ".bubble_wb"}, {31'd0, wb_en_out}, 32'd0);
        check({tag, ".bubble_ren"}, {31'd0, mem_r_en_out}, 32'd0);
      end
    end
    check({tag, ".done_in_budget"}, {31'd0, done}, 32'd1);
    check({tag, ".freeze_cycles"}, frz, exp_frz);
    got = sb.pop_front();
    if (done) begin
      check({tag, ".wb_en_out"}, {31'd0, wb_en_out}, {31'd0, got.wb});
      check({tag, ".mem_r_en_out"}, {31'd0, mem_r_en_out}, {31'd0, got.r_en});
      check({tag, ".alu_res_out"}, alu_res_out, got.alu);
      check({tag, ".mem_rdata_out"}, mem_rdata_out, got.rdata);
      check({tag, ".dest_out"}, {28'd0, dest_out}, {28'd0, got.dest});
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    #12;
    check("rst.mem_req", {31'd0, mem_req}, 32'd0);
    check("rst.freeze", {31'd0, freeze}, 32'd0);
    check("rst.wb_en_out", {31'd0, wb_en_out}, 32'd0);
    check("rst.alu_res_out", alu_res_out, 32'd0);
    check("rst.mem_err", {31'd0, mem_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;

    do_op("nonmem", 1, 0, 0, 32'h55, 32'h0, 4'd3, 0, 32'h0);
    do_op("load_ack3", 1, 1, 0, 32'd1032, 32'h0, 4'd5, 3, 32'hDEADBEEF);
    do_op("store_ack0", 0, 0, 1, 32'd1028, 32'h1234, 4'd0, 0, 32'h0);
    do_op("b2b_load1", 1, 1, 0, 32'd1100, 32'h0, 4'd7, 1, 32'hA5A5_0001);
    do_op("b2b_load2", 1, 1, 0, 32'd1104, 32'h0, 4'd8, 0, 32'h0BAD_F00D);
    do_op("wrap_store", 0, 0, 1, 32'd4, 32'hCAFE, 4'd1, 2, 32'h0);
    do_op("low_bits", 1, 1, 0, 32'd1035, 32'h0, 4'd9, 0, 32'h1111_2222);
    check("no_err_yet", {31'd0, mem_err}, 32'd0);

    do_op("timeout", 1, 1, 0, 32'd1040, 32'h0, 4'd6, -1, 32'hFFFF_FFFF);
    check("timeout.mem_err", {31'd0, mem_err}, 32'd1);
    do_op("after_to", 1, 0, 0, 32'h77, 32'h0, 4'd2, 0, 32'h0);
    check("err_sticky", {31'd0, mem_err}, 32'd1);

    // Reset in the middle of an outstanding load: abandoned, nothing to WB.
    wb_en_in = 1; mem_r_en_in = 1; alu_res_in = 32'd1048; dest_in = 4'd4;
    repeat (3) begin @(posedge clk); #1; end
    check("midrst.pre_freeze", {31'd0, freeze}, 32'd1);
    #2 rst = 0;
    #1;
    check("midrst.mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst.freeze", {31'd0, freeze}, 32'd0);
    check("midrst.wb_en_out", {31'd0, wb_en_out}, 32'd0);
    check("midrst.alu_res_out", alu_res_out, 32'd0);
    check("midrst.dest_out", {28'd0, dest_out}, 32'd0);
    check("midrst.mem_err", {31'd0, mem_err}, 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    do_op("post_rst", 1, 0, 0, 32'h99, 32'h0, 4'd10, 0, 32'h0);

    do_op("rw_both", 1, 1, 1, 32'd1060, 32'hBEEF, 4'd11, 1, 32'h2222_3333);
    check("rw_both.mem_err", {31'd0, mem_err}, 32'd1);
    do_op("rw_after", 1, 0, 0, 32'h12, 32'h0, 4'd12, 0, 32'h0);
    check("rw_err_sticky", {31'd0, mem_err}, 32'd1);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
